// File: rtl/strobe_period_monitor.sv
// Measures the clk-cycle interval between consecutive rising edges of a strobe
// and presents each interval on a valid/ready port with mismatch, saturation and drop flags.
module strobe_period_monitor #(
  parameter int WIDTH  = 16,
  parameter int EXPECT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             period_err,
  output logic             overflow,
  output logic             missed,
  output logic [7:0]       edge_count
);

  localparam longint unsigned CNT_LIMIT = (WIDTH >= 63) ? 64'h7FFF_FFFF_FFFF_FFFF
                                                        : ((64'd1 << WIDTH) - 64'd1);
  localparam logic [WIDTH-1:0] MAX_CNT  = '1;
  localparam logic [WIDTH-1:0] EXPECT_W = WIDTH'(EXPECT);

  // An expected period the counter can never reach would flag every result.
  if (WIDTH < 1 || EXPECT < 0 || longint'(EXPECT) > longint'(CNT_LIMIT)) begin : g_bad_params
    $error("strobe_period_monitor: EXPECT=%0d does not fit in WIDTH=%0d", EXPECT, WIDTH);
  end

  typedef enum logic {
    S_IDLE,
    S_MEASURE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_strobe_q;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_period_valid;
  logic             r_period_err;
  logic             r_overflow;
  logic             r_missed;
  logic [7:0]       r_edge_count;

  logic w_rise;
  logic w_accept;
  logic w_result;
  logic w_load;
  logic w_cnt_sat;
  logic w_err;

  assign w_rise    = strobe & ~r_strobe_q;
  assign w_accept  = r_period_valid & period_ready;
  assign w_result  = (r_state == S_MEASURE) & w_rise;
  assign w_load    = w_result & (~r_period_valid | w_accept);
  assign w_cnt_sat = (r_cnt == MAX_CNT);
  assign w_err     = (EXPECT != 0) && (r_cnt != EXPECT_W);

  // NOTE: every register below uses <= so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    w_next_state = r_state;
    if (r_state == S_IDLE && w_rise) w_next_state = S_MEASURE;
  end

  // NOTE: reset is synchronous; a reset edge discards any partial interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe_q     <= 1'b0;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_period_err   <= 1'b0;
      r_overflow     <= 1'b0;
      r_missed       <= 1'b0;
      r_edge_count   <= 8'd0;
    end else begin
      r_strobe_q <= strobe;

      if (w_rise) begin
        r_cnt        <= WIDTH'(1);
        r_edge_count <= r_edge_count + 8'd1;
      end else if (r_state == S_MEASURE) begin
        if (w_cnt_sat) r_overflow <= 1'b1;
        else           r_cnt      <= r_cnt + WIDTH'(1);
      end

      // A result arriving while the previous one is still held is dropped.
      if (w_load) begin
        r_period       <= r_cnt;
        r_period_err   <= w_err;
        r_period_valid <= 1'b1;
      end else if (w_result) begin
        r_missed       <= 1'b1;
      end else if (w_accept) begin
        r_period_valid <= 1'b0;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign period_err   = r_period_err;
  assign overflow     = r_overflow;
  assign missed       = r_missed;
  assign edge_count   = r_edge_count;

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Bench for strobe_period_monitor: a 16-bit and a 4-bit instance share one stimulus
// stream and are compared every cycle against an interval-arithmetic model.
module tb_strobe_period_monitor;

  logic clk = 1'b0;
  logic rst;
  logic strobe;
  logic period_ready;

  logic [15:0] p16;
  logic [3:0]  p4;
  logic        v16, v4, e16, e4, o16, o4, m16, m4;
  logic [7:0]  ec16, ec4;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  strobe_period_monitor #(.WIDTH(16), .EXPECT(8)) u_d16 (
    .clk(clk), .rst(rst), .strobe(strobe),
    .period(p16), .period_valid(v16), .period_ready(period_ready),
    .period_err(e16), .overflow(o16), .missed(m16), .edge_count(ec16)
  );

  strobe_period_monitor #(.WIDTH(4), .EXPECT(8)) u_d4 (
    .clk(clk), .rst(rst), .strobe(strobe),
    .period(p4), .period_valid(v4), .period_ready(period_ready),
    .period_err(e4), .overflow(o4), .missed(m4), .edge_count(ec4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers the cycle of the last rising edge and derives each interval
  // as a cycle difference clipped to the counter's largest value.
  typedef struct {
    bit sq;
    bit meas;
    int last;
    int per;
    bit val;
    bit err;
    bit ovf;
    bit mis;
    int ec;
  } mdl_t;

  mdl_t m [2];
  int   mx [2];
  int   cyc = 0;

  initial begin
    mx[0] = 65535;
    mx[1] = 15;
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
  end

  always @(posedge clk) begin : model
    bit rise, acc;
    int d, mv;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m[i] = '{default: 0};
      end else begin
        rise    = strobe && !m[i].sq;
        m[i].sq = strobe;
        acc     = m[i].val && period_ready;
        d       = cyc - m[i].last;
        if (rise && m[i].meas) begin
          mv = (d > mx[i]) ? mx[i] : d;
          if (!m[i].val || acc) begin
            m[i].per = mv;
            m[i].err = (mv != 8);
            m[i].val = 1'b1;
          end else begin
            m[i].mis = 1'b1;
          end
        end else if (acc) begin
          m[i].val = 1'b0;
        end
        if (!rise && m[i].meas && d >= mx[i]) m[i].ovf = 1'b1;
        if (rise) begin
          m[i].meas = 1'b1;
          m[i].last = cyc;
          m[i].ec   = (m[i].ec + 1) % 256;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      check("d16.period",     p16,  m[0].per);
      check("d16.valid",      v16,  m[0].val);
      check("d16.err",        e16,  m[0].err);
      check("d16.overflow",   o16,  m[0].ovf);
      check("d16.missed",     m16,  m[0].mis);
      check("d16.edge_count", ec16, m[0].ec);
      check("d4.period",      p4,   m[1].per);
      check("d4.valid",       v4,   m[1].val);
      check("d4.err",         e4,   m[1].err);
      check("d4.overflow",    o4,   m[1].ovf);
      check("d4.missed",      m4,   m[1].mis);
      check("d4.edge_count",  ec4,  m[1].ec);
    end
  end

  task automatic tick(input bit s, input bit r, input bit rdy);
    @(negedge clk);
    strobe       = s;
    rst          = r;
    period_ready = rdy;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    strobe       = 1'b0;
    rst          = 1'b1;
    period_ready = 1'b1;

    // Reset state
    tick(0, 1, 1);
    settle();
    check("rst.period", p16, 0);
    check("rst.valid",  v16, 0);
    check("rst.err",    e16, 0);
    check("rst.ovf",    o16, 0);
    check("rst.missed", m16, 0);
    check("rst.ec",     ec16, 0);
    cmp_en = 1'b1;

    // Period 8 with EXPECT=8, 256 pulses to wrap edge_count
    for (int k = 0; k < 256; k++) begin
      tick(1, 0, 1);
      settle();
      if (k == 0) begin
        check("p8.first.ec",    ec16, 1);
        check("p8.first.valid", v16, 0);
      end
      if (k == 1) begin
        check("p8.valid",  v16, 1);
        check("p8.period", p16, 8);
        check("p8.err",    e16, 0);
      end
      for (int j = 1; j < 8; j++) tick(0, 0, 1);
    end
    check("p8.ec_wrap16", ec16, 0);
    check("p8.ec_wrap4",  ec4, 0);

    // Period 9: every measurement mismatches
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 1);
      for (int j = 1; j < 9; j++) tick(0, 0, 1);
    end
    check("p9.period16", p16, 9);
    check("p9.err16",    e16, 1);
    check("p9.period4",  p4, 9);
    check("p9.err4",     e4, 1);
    check("p9.ovf",      o16, 0);
    check("p9.missed",   m16, 0);

    // Backpressure: three pulses with ready low
    tick(0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 0);
      settle();
      if (k == 1) begin
        check("bp.hold.valid",  v16, 1);
        check("bp.hold.period", p16, 8);
        check("bp.hold.missed", m16, 0);
      end
      if (k == 2) begin
        check("bp.drop.missed", m16, 1);
        check("bp.drop.valid",  v16, 1);
        check("bp.drop.period", p16, 8);
      end
      for (int j = 1; j < 8; j++) tick(0, 0, 0);
    end
    tick(0, 0, 1);
    settle();
    check("bp.acc.valid",  v16, 0);
    check("bp.acc.period", p16, 8);
    tick(0, 0, 0);

    // Accept and new result on the same edge
    tick(0, 1, 0);
    tick(1, 0, 0);
    for (int j = 1; j < 8; j++) tick(0, 0, 0);
    tick(1, 0, 0);
    for (int j = 1; j < 10; j++) tick(0, 0, 0);
    tick(1, 0, 1);
    settle();
    check("same.valid",  v16, 1);
    check("same.period", p16, 10);
    check("same.err",    e16, 1);
    check("same.missed", m16, 0);
    for (int j = 1; j < 8; j++) tick(0, 0, 1);

    // 21-cycle gap saturates the 4-bit counter only
    tick(1, 0, 1);
    for (int j = 0; j < 20; j++) tick(0, 0, 1);
    tick(1, 0, 1);
    settle();
    check("sat.ovf4",     o4, 1);
    check("sat.period4",  p4, 15);
    check("sat.err4",     e4, 1);
    check("sat.ovf16",    o16, 0);
    check("sat.period16", p16, 21);
    for (int j = 1; j < 8; j++) tick(0, 0, 1);

    // Reset three cycles after a pulse, then restart measurement
    tick(1, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 1, 1);
    settle();
    check("mid.period", p16, 0);
    check("mid.valid",  v16, 0);
    check("mid.err",    e16, 0);
    check("mid.ovf4",   o4, 0);
    check("mid.missed", m16, 0);
    check("mid.ec",     ec16, 0);
    tick(1, 0, 1);
    settle();
    check("re.ec",    ec16, 1);
    check("re.valid", v16, 0);
    for (int j = 1; j < 8; j++) tick(0, 0, 1);
    tick(1, 0, 1);
    settle();
    check("re.period", p16, 8);
    check("re.valid2", v16, 1);
    check("re.ec2",    ec16, 2);
    for (int j = 1; j < 8; j++) tick(0, 0, 1);

    // Strobe held high: one edge only
    for (int j = 0; j < 30; j++) tick(1, 0, 1);
    settle();
    check("held.ec", ec16, 3);
    for (int j = 0; j < 4; j++) tick(0, 0, 1);
    settle();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strobe_period_monitor.md
Name: strobe_period_monitor

Overview:
- Consumes a periodic single-bit strobe, such as a divide-by-N tick from a free-running counter, and measures the clock-cycle interval between consecutive rising edges.
- Presents each measurement on a valid/ready output, flags deviation from an expected period, and records saturation and dropped results.
- Acts as the receive/checking end of the design's counter-derived tick generators. Used on-chip for timer self-check and in benches as a reusable monitor.

Parameters:
- WIDTH, 16, width of interval counter and period output.
- EXPECT, 8, expected period in clk cycles; 0 disables mismatch checking.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- strobe  input  1  monitored tick, synchronous to clk.
- period  output  WIDTH  last measured rising-edge-to-rising-edge interval.
- period_valid  output  1  period holds an unconsumed measurement.
- period_ready  input  1  consumer accepts period when valid&ready.
- period_err  output  1  qualifies period: EXPECT!=0 and period!=EXPECT.
- overflow  output  1  sticky: interval counter saturated at least once.
- missed  output  1  sticky: a measurement was dropped under backpressure.
- edge_count  output  8  rising edges seen since reset, wraps 255->0.

Behaviour:
- Reset: rst high at a clk edge clears all state.
  - period=0, period_valid=0, period_err=0, overflow=0, missed=0, edge_count=0.
  - Internal strobe_q=0, cnt=0, state=IDLE.
  - Reset overrides every other event in the same cycle, including mid-measurement; the partial interval is discarded.
- Edge detect: rise = strobe & ~strobe_q, evaluated at each clk edge; strobe_q<=strobe every cycle.
  - A strobe held high yields one rise only.
  - A strobe high in the first cycle after reset counts as a rise.
- State IDLE (no reference edge yet):
  - On rise: cnt<=1, edge_count++, go MEASURE.
  - No measurement is produced.
- State MEASURE:
  - Each cycle without rise: cnt<=cnt+1, saturating at 2^WIDTH-1.
  - When cnt is already 2^WIDTH-1 and would increment, set overflow.
  - On rise: the measured value is cnt (cycles since previous rise); cnt<=1; edge_count++; stay MEASURE.
  - Example: strobe high one cycle in every 8 gives a measured value of 8.
- Result load on rise in MEASURE:
  - If period_valid=0, or period_valid&period_ready in that same cycle: period<=cnt, period_err<=(EXPECT!=0 && cnt!=EXPECT), period_valid<=1.
  - Otherwise: period, period_err and period_valid are held, the new value is dropped, and missed<=1.
- Handshake:
  - Transfer occurs on a clk edge with period_valid&period_ready.
  - With no simultaneous load, period_valid<=0; period and period_err hold their last values.
  - period and period_err are stable while period_valid=1 and not accepted.
  - period_ready while period_valid=0 has no effect.
- Latency: period_valid rises at the same clk edge that samples the rising strobe; the output is visible one cycle after strobe goes high.
- Saturated interval: reported as all-ones with period_err set (when EXPECT!=0); overflow stays set until reset.
- Arithmetic: EXPECT is compared at WIDTH bits. If EXPECT > 2^WIDTH-1, every period is an error; this parameter combination is illegal and must be rejected at elaboration.

Test Plan:
- Strobe pulsed high 1 cycle every 8, period_ready=1, EXPECT=8:
  - first pulse -> no output, edge_count=1;
  - each later pulse -> period_valid 1 cycle, period=8, period_err=0;
  - after 256 pulses edge_count=0.
- Same stimulus with strobe every 9 cycles -> period=9, period_err=1 on every measurement; overflow=0, missed=0.
- period_ready=0, strobe every 8, three pulses:
  - first period=8 held with valid=1;
  - third pulse sets missed=1;
  - then ready=1 for 1 cycle -> valid drops, period still 8.
- Accept and new edge in same cycle -> period_valid stays 1, new period loaded, missed=0.
- WIDTH=4, one pulse then none for 20 cycles, then a pulse:
  - overflow=1;
  - period=15, period_err=1.
- Strobe every 8, rst pulsed 1 cycle 3 cycles after a pulse:
  - all outputs 0 next cycle;
  - next pulse re-enters MEASURE with no output;
  - following pulse gives period=8;
  - strobe held high 30 cycles -> edge_count increments once.
